// File: rtl/encryption_pipe.sv
// encryption_pipe
//   Six-register byte encryption pipeline: an input capture register followed
//   by five transform registers (xor key, rotate-left, invert, bit-reverse,
//   rotate-right). The last register drives e_data directly. The whole pipe
//   advances as one unit, so a downstream stall freezes every stage.
//
//   Parameters
//     N            data/key width
//     ROT          rotate amount, 0 < ROT < N
//     BLOCK_BYTES  bytes per message block (out_last marks the final one)
//
//   Ports
//     clock      rising-edge clock
//     reset_n    synchronous active-low reset
//     in_valid   data/key present
//     in_ready   pipe can take a byte this cycle
//     data, key  plaintext byte and its key
//     out_valid  e_data holds an encrypted byte
//     out_ready  downstream takes e_data this cycle
//     e_data     encrypted byte (registered)
//     out_last   final byte of a block
//     blk_cnt    completed blocks consumed (only with ENCRYPT_BLOCK_COUNT_EN)
//
//   Build option: define ENCRYPT_BLOCK_COUNT_EN to add the blk_cnt output.
module encryption_pipe #(
  parameter int N           = 8,
  parameter int ROT         = 3,
  parameter int BLOCK_BYTES = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] e_data,
`ifdef ENCRYPT_BLOCK_COUNT_EN
  output logic [15:0]  blk_cnt,
`endif
  output logic         out_last
);

  localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_BYTES - 1);

  function automatic logic [N-1:0] f_rotl(input logic [N-1:0] x);
    return (x << ROT) | (x >> (N - ROT));
  endfunction

  function automatic logic [N-1:0] f_rotr(input logic [N-1:0] x);
    return (x >> ROT) | (x << (N - ROT));
  endfunction

  function automatic logic [N-1:0] f_bitrev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = x[N-1-i];
    end
    return r;
  endfunction

  logic [N-1:0]  r_in_data;
  logic [N-1:0]  r_in_key;
  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic [N-1:0]  r_s3;
  logic [N-1:0]  r_s4;
  logic [N-1:0]  r_e_data;
  // Bit 0 is the input capture register, bit 5 the output register.
  logic [5:0]    r_vld;
  logic [5:0]    r_last;
  logic [CW-1:0] r_byte_cnt;

  logic          w_advance;
  logic          w_cnt_last;
  logic [N-1:0]  w_s1;
  logic [N-1:0]  w_s2;
  logic [N-1:0]  w_s3;
  logic [N-1:0]  w_s4;
  logic [N-1:0]  w_e;

  assign w_advance  = !r_vld[5] || out_ready;
  assign w_cnt_last = (r_byte_cnt == CNT_MAX);

  assign w_s1 = r_in_data ^ r_in_key;
  assign w_s2 = f_rotl(r_s1);
  assign w_s3 = ~r_s2;
  assign w_s4 = f_bitrev(r_s3);
  assign w_e  = f_rotr(r_s4);

  // Reset empties the pipe, so ready is forced high while it is asserted.
  assign in_ready  = w_advance || !reset_n;
  assign out_valid = r_vld[5];
  assign out_last  = r_last[5];
  assign e_data    = r_e_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_in_data  <= '0;
      r_in_key   <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_s4       <= '0;
      r_e_data   <= '0;
      r_vld      <= '0;
      r_last     <= '0;
      r_byte_cnt <= '0;
    end else if (w_advance) begin
      r_in_data <= data;
      r_in_key  <= key;
      r_s1      <= w_s1;
      r_s2      <= w_s2;
      r_s3      <= w_s3;
      r_s4      <= w_s4;
      r_e_data  <= w_e;
      r_vld     <= {r_vld[4:0], in_valid};
      // The last flag is only ever set on a valid slot, so it never leaks onto a bubble.
      r_last    <= {r_last[4:0], in_valid && w_cnt_last};
      if (in_valid) begin
        r_byte_cnt <= w_cnt_last ? '0 : r_byte_cnt + 1'b1;
      end
    end
  end

`ifdef ENCRYPT_BLOCK_COUNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_blk_cnt <= '0;
    end else if (r_vld[5] && out_ready && r_last[5]) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: doc/encryption_pipe.md
ENCRYPTION_PIPE -- requirements
Module: encryption_pipe

Interface
REQ-001 Parameter: N, 8, data/key width in bits.
REQ-002 Parameter: ROT, 3, rotate amount in bits, 0 < ROT < N.
REQ-003 Parameter: BLOCK_BYTES, 32, bytes per message block.
REQ-004 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset_n  input  1  synchronous, active-low reset.
REQ-006 Port: in_valid  input  1  data/key present this cycle.
REQ-007 Port: in_ready  output  1  block can accept a byte this cycle.
REQ-008 Port: data  input  N  plaintext byte.
REQ-009 Port: key  input  N  key byte, sampled with its data byte.
REQ-010 Port: out_valid  output  1  e_data holds a valid encrypted byte.
REQ-011 Port: out_ready  input  1  downstream accepts e_data this cycle.
REQ-012 Port: e_data  output  N  encrypted byte, registered.
REQ-013 Port: out_last  output  1  qualifies the final byte of each BLOCK_BYTES block.

Function
REQ-014 Transform, exact inverse of the team's decryption pipeline: s1 = data XOR key; s2 = rotate-left(s1, ROT); s3 = NOT s2; s4 = bit-reverse s3 (bit i <- bit N-1-i); e_data = rotate-right(s4, ROT).
REQ-015 Five registered stages, one transform step each; per-stage valid bit; data and key travel together.
REQ-016 Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-017 advance = !out_valid || out_ready; in_ready = advance (combinational); when advance=0, all stage registers and valids hold.
REQ-018 Latency: byte accepted at edge k appears with out_valid=1 after edge k+5 if advance stays 1; throughput one byte/cycle.
REQ-019 e_data, out_last stable while out_valid && !out_ready.
REQ-020 Byte counter (0..BLOCK_BYTES-1) increments on each accepted input; wraps BLOCK_BYTES-1 -> 0; its last-flag travels with the byte to out_last.
REQ-021 Bubble (in_valid=0 with advance=1) shifts an invalid slot through; counter unchanged.
REQ-022 Accept and output consume in the same cycle are both honored; no byte lost or duplicated.
REQ-023 Decrypting e_data with the same key through the team decryption pipeline returns data exactly.

Reset
REQ-024 reset_n=0 at a rising edge clears all stage valids, byte counter, e_data=0, out_valid=0, out_last=0.
REQ-025 in_ready=1 during and after reset (pipeline empty).
REQ-026 Reset mid-block discards all in-flight bytes; next accepted byte is byte 0 of a new block.

Configuration
REQ-027 Macro ENCRYPT_BLOCK_COUNT_EN: when defined, adds output blk_cnt (16 bits), reset 0, incremented when a byte with out_last=1 is consumed, wraps 0xFFFF -> 0.
REQ-028 Without ENCRYPT_BLOCK_COUNT_EN: blk_cnt port and its counter do not exist; all other behaviour identical.

Verification
REQ-029 data=0x00 key=0x00 accepted, out_ready=1 -> e_data=0xFF with out_valid 5 cycles later.
REQ-030 data=0x01 key=0x00 -> e_data=0xFD; data=0xA5 key=0x5A -> e_data=0x00.
REQ-031 64 back-to-back bytes, out_ready=1 -> 64 outputs on consecutive cycles, out_last on outputs 32 and 64 only; blk_cnt=2 if enabled.
REQ-032 Stream 10 bytes, hold out_ready=0 for 7 cycles mid-stream -> in_ready=0 while out_valid stalled, e_data held, all 10 bytes emitted in order.
REQ-033 Reset after 20 bytes accepted -> out_valid=0 next cycle; following 32 bytes give out_last only on the 32nd.
REQ-034 Random data/key loopback through decryption pipeline, 1000 bytes with random in_valid/out_ready -> recovered data matches in order.
